// File: rtl/trng_pkg.sv
// ---------------------------------------------------------------------------
// trng_pkg
// Shared definitions for the raw-entropy bit collector path:
//   - pair_state_e : von Neumann pair FSM states
//   - DEF_WIDTH    : default packed word width
//   - DEF_OVR_W    : default overrun counter width
//   - PAIR_ONE / PAIR_ZERO : {first, second} pair codes that emit a bit
// ---------------------------------------------------------------------------
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } pair_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OVR_W = 16;

    // {pair_a, b}: 10 emits a one, 01 emits a zero, 00/11 are discarded
    localparam logic [1:0] PAIR_ONE  = 2'b10;
    localparam logic [1:0] PAIR_ZERO = 2'b01;

endpackage

// File: rtl/trng_bit_collector_vn_debias.sv
// ---------------------------------------------------------------------------
// vn_debias
// Von Neumann debiaser: consumes one raw bit per cycle while en is high,
// pairs consecutive bits and emits one unbiased bit for each unequal pair.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : enable; low forces the pair FSM back to IDLE
//   din        : raw input bit
//   emit       : a debiased bit is produced this cycle (combinational)
//   emit_bit   : value of the produced bit (valid with emit)
// ---------------------------------------------------------------------------
module vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic emit,
    output logic emit_bit
);

    pair_state_e state_q, state_d;
    logic        pair_a_q, pair_a_d;

    // Pair FSM next-state, first-bit capture and emit decode
    always_comb begin
        state_d  = state_q;
        pair_a_d = pair_a_q;
        emit     = 1'b0;
        emit_bit = 1'b0;
        if (!en) begin
            state_d  = ST_IDLE;
            pair_a_d = 1'b0;
        end else begin
            case (state_q)
                // IDLE behaves as FIRST: the bit present when en rises is
                // the first half of the first pair
                ST_IDLE, ST_FIRST: begin
                    pair_a_d = din;
                    state_d  = ST_SECOND;
                end
                ST_SECOND: begin
                    state_d = ST_FIRST;
                    case ({pair_a_q, din})
                        PAIR_ONE: begin
                            emit     = 1'b1;
                            emit_bit = 1'b1;
                        end
                        PAIR_ZERO: begin
                            emit     = 1'b1;
                            emit_bit = 1'b0;
                        end
                        default: begin
                            emit     = 1'b0;
                            emit_bit = 1'b0;
                        end
                    endcase
                end
                default: begin
                    state_d  = ST_IDLE;
                    pair_a_d = 1'b0;
                end
            endcase
        end
    end

    // Pair FSM state and first-bit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pair_a_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pair_a_q <= pair_a_d;
        end
    end

endmodule

// File: rtl/trng_bit_collector.sv
// ---------------------------------------------------------------------------
// trng_bit_collector
// Debiases the sampled raw-entropy stream, packs surviving bits MSB-first
// into WIDTH-bit words and offers them over valid/ready. Words completing
// while the holding register is still occupied are dropped and counted.
// Ports:
//   d_clk, d_rst : clock, asynchronous active-high reset
//   d_input      : raw sampled bit, one per cycle
//   en           : collection enable
//   out_data     : packed word (holding register)
//   out_valid    : holding register holds an unconsumed word
//   out_ready    : downstream accepts when out_valid && out_ready
//   ovr_cnt      : saturating count of dropped words
// ---------------------------------------------------------------------------
module trng_bit_collector
    import trng_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OVR_W = DEF_OVR_W
) (
    input  logic             d_clk,
    input  logic             d_rst,
    input  logic             d_input,
    input  logic             en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OVR_W-1:0] ovr_cnt
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             emit_s;
    logic             bit_s;
    logic             complete_s;
    logic [WIDTH-1:0] word_s;

    // Only WIDTH-1 bits are ever buffered; the last one arrives with completion
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;

    vn_debias u_vn_debias (
        .clk      (d_clk),
        .rst      (d_rst),
        .en       (en),
        .din      (d_input),
        .emit     (emit_s),
        .emit_bit (bit_s)
    );

    // Packing shift register and bit counter
    always_comb begin
        word_s     = {shift_q, bit_s};
        complete_s = emit_s && (cnt_q == CNT_W'(WIDTH - 1));
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        if (!en || complete_s) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (emit_s) begin
            shift_d = word_s[WIDTH-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Holding register, handshake and saturating overrun counter
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (complete_s) begin
            // A same-cycle handshake frees the slot, so the new word loads
            // without a bubble
            if (!valid_q || out_ready) begin
                data_d  = word_s;
                valid_d = 1'b1;
            end else if (ovr_q != {OVR_W{1'b1}}) begin
                ovr_d = ovr_q + OVR_W'(1);
            end else begin
                ovr_d = ovr_q;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers
    always_ff @(posedge d_clk or posedge d_rst) begin
        if (d_rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ovr_cnt   = ovr_q;

endmodule

// File: doc/trng_bit_collector.md
# trng_bit_collector

Consumer of the sampled raw-entropy bit stream produced by the XOR-tree sampling flip-flop. It takes one raw bit per clock, removes bias with von Neumann pairing, packs the surviving bits into WIDTH-bit words, and offers each word to the downstream post-processor or host link over a valid/ready handshake. It sits between the sampler and the conditioning or transport logic. It is the reader side of the sampler's one-bit-per-cycle stream.

## Interface
- WIDTH, 8: bits per output word; legal range 2..32.
- OVR_W, 16: width of the saturating overrun counter.
- d_clk  input  1  single system clock; all state updates on its rising edge.
- d_rst  input  1  reset, asynchronous, active-high.
- d_input  input  1  raw sampled bit, already registered by the sampler; one new bit per cycle.
- en  input  1  collection enable; bits are consumed only while high.
- out_data  output  WIDTH  packed debiased word; 0 after reset.
- out_valid  output  1  holding register contains an unconsumed word; 0 after reset.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- ovr_cnt  output  OVR_W  count of completed words that were dropped because the holding register was full; saturates at all-ones; 0 after reset.

## Operation
- Pair FSM states:
  - IDLE: en=0.
  - FIRST: capture d_input into pair_a.
  - SECOND: evaluate the pair.
- FSM transitions:
  - IDLE→FIRST on en=1; the bit present in that same cycle is captured.
  - FIRST→SECOND, SECOND→FIRST, while en=1.
  - Any state→IDLE on en=0.
- Pair rule, evaluated in SECOND with b = d_input:
  - (pair_a, b) = 10 emits bit 1.
  - 01 emits bit 0.
  - 00 and 11 emit nothing.
- Emitted bit: shift_reg <= {shift_reg[WIDTH-2:0], bit}, bit_cnt++. The first emitted bit therefore ends in the MSB.
- Word completion is the cycle bit_cnt = WIDTH-1 and a bit is emitted. The full word, including this bit, goes to the holding path, and shift_reg/bit_cnt clear.
- Holding path on completion:
  - If out_valid=0, or out_valid && out_ready in the same cycle: out_data <= word, out_valid <= 1.
  - Otherwise: word dropped, ovr_cnt increments (saturating); out_data is unchanged.
- Handshake:
  - out_valid && out_ready with no completion that cycle clears out_valid.
  - out_data holds stable while out_valid=1 and out_ready=0.
- en deasserted mid-word: FSM goes to IDLE, and pair_a, shift_reg and bit_cnt clear. The holding register and out_valid are unaffected, so a pending word can still be drained.
- Reset asserted at any time clears all state immediately (asynchronous), including any pending word.

## Timing
- One raw bit consumed per cycle while en=1. At most one debiased bit is produced per 2 cycles.
- Latency: out_valid rises on the clock edge that samples the completing SECOND bit, and is visible the following cycle. Minimum time from en rising to out_valid is 2·WIDTH cycles.
- Back-to-back words: a handshake in the completion cycle loads the new word with no bubble.
- ovr_cnt updates on the edge of the drop event; it never wraps.
- Reset release: the first sampled edge with d_rst=0 and en=1 starts in FIRST.

## Structure
- Shared package `trng_pkg`:
  - Pair FSM state enum (IDLE, FIRST, SECOND).
  - Default WIDTH and OVR_W constants.
  - Pair decode constants.
- Optional sub-module `vn_debias`: pair FSM plus emit/bit outputs. It is reusable by other entropy paths.
- The top level holds the packing shift register, the holding register and the overrun counter.

## Test plan
- Reset then en=1, feeding the pairs 10,01,10,10,01,01,10,01 (16 cycles), out_ready=0 → out_data=0xB2, out_valid=1 on cycle 17, ovr_cnt=0.
- Pairs 00 and 11 interleaved between the above pairs → same 0xB2, with delay extended by 2 cycles per discarded pair.
- out_ready=0, feeding three complete words → first word held, ovr_cnt=2, out_data unchanged; then out_ready=1 for 1 cycle → out_valid=0.
- out_ready=1 in the exact cycle a second word completes → second word loaded with no gap, ovr_cnt=0.
- en dropped after 5 emitted bits, then re-enabled with a full 8-bit pattern → out_data equals the new pattern only; the partial bits are discarded.
- d_rst pulsed asynchronously (between edges) while out_valid=1 and mid-pair → out_valid, out_data, ovr_cnt all 0 immediately; the FSM restarts cleanly.
